// File: rtl/elevator_controller.sv
// Single-car elevator controller for eight floors.
// Latches floor calls into a pending mask and serves them with a
// three-state IDLE/MOVE/DOOR machine. Travel continues in one direction
// while calls remain ahead, then reverses.
module elevator_controller #(
    parameter int unsigned TRAVEL_CYCLES = 8,
    parameter int unsigned DOOR_CYCLES   = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] call_req,
    output logic [2:0] floor,
    output logic [7:0] pending,
    output logic       moving,
    output logic       dir_up,
    output logic       door_open
);

    typedef enum logic [1:0] {
        IDLE,
        MOVE,
        DOOR
    } state_t;

    localparam logic [7:0] TRAVEL_LOAD = 8'(TRAVEL_CYCLES - 1);
    localparam logic [7:0] DOOR_LOAD   = 8'(DOOR_CYCLES - 1);

    state_t     state_q, state_d;
    logic [2:0] floor_q, floor_d;
    logic [7:0] pending_q, pending_d;
    logic       dir_up_q, dir_up_d;
    logic [7:0] cnt_q, cnt_d;

    logic       above, below, here;
    logic       ahead, behind;
    logic [2:0] next_floor;

    // Classify outstanding calls relative to the cab position.
    always_comb begin
        // Mask of bits strictly above floor_q; shifting out of 8 bits yields an empty mask at floor 7.
        above      = |(pending_q & ~((8'd2 << floor_q) - 8'd1));
        below      = |(pending_q & ((8'd1 << floor_q) - 8'd1));
        here       = pending_q[floor_q];
        ahead      = dir_up_q ? above : below;
        behind     = dir_up_q ? below : above;
        next_floor = dir_up_q ? (floor_q + 3'd1) : (floor_q - 3'd1);
    end

    // Next-state, floor, direction, timer and pending-mask logic.
    always_comb begin
        state_d  = state_q;
        floor_d  = floor_q;
        dir_up_d = dir_up_q;
        cnt_d    = cnt_q;

        case (state_q)
            IDLE: begin
                if (here) begin
                    state_d = DOOR;
                    cnt_d   = DOOR_LOAD;
                end else if (above) begin
                    state_d  = MOVE;
                    dir_up_d = 1'b1;
                    cnt_d    = TRAVEL_LOAD;
                end else if (below) begin
                    state_d  = MOVE;
                    dir_up_d = 1'b0;
                    cnt_d    = TRAVEL_LOAD;
                end
            end
            MOVE: begin
                if (cnt_q == 8'd0) begin
                    floor_d = next_floor;
                    if (pending_q[next_floor]) begin
                        state_d = DOOR;
                        cnt_d   = DOOR_LOAD;
                    end else begin
                        cnt_d = TRAVEL_LOAD;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            DOOR: begin
                if (call_req[floor_q]) begin
                    cnt_d = DOOR_LOAD;
                end else if (cnt_q == 8'd0) begin
                    if (ahead) begin
                        state_d = MOVE;
                        cnt_d   = TRAVEL_LOAD;
                    end else if (behind) begin
                        state_d  = MOVE;
                        dir_up_d = ~dir_up_q;
                        cnt_d    = TRAVEL_LOAD;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A call for the floor the door is open at is absorbed, never latched.
        pending_d = pending_q | call_req;
        if (state_d == DOOR) begin
            pending_d[floor_d] = 1'b0;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            floor_q   <= '0;
            pending_q <= '0;
            dir_up_q  <= 1'b1;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            floor_q   <= floor_d;
            pending_q <= pending_d;
            dir_up_q  <= dir_up_d;
            cnt_q     <= cnt_d;
        end
    end

    assign floor     = floor_q;
    assign pending   = pending_q;
    assign dir_up    = dir_up_q;
    assign moving    = (state_q == MOVE);
    assign door_open = (state_q == DOOR);

endmodule

// File: tb/tb_elevator_controller.sv
// Testbench for elevator_controller: directed scenarios plus randomized
// call traffic, all checked against a cycle-level behavioural model.
module tb_elevator_controller;

    localparam int TRAVEL = 8;
    localparam int DOOR   = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] call_req = '0;
    logic [2:0] floor;
    logic [7:0] pending;
    logic       moving;
    logic       dir_up;
    logic       door_open;

    int total = 0;
    int bad   = 0;

    // Behavioural model: mode 0 = idle, 1 = travelling, 2 = door open.
    int         m_mode  = 0;
    int         m_floor = 0;
    logic [7:0] m_pend  = '0;
    logic       m_up    = 1'b1;
    int         m_el    = 0;

    elevator_controller #(
        .TRAVEL_CYCLES(TRAVEL),
        .DOOR_CYCLES  (DOOR)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .call_req (call_req),
        .floor    (floor),
        .pending  (pending),
        .moving   (moving),
        .dir_up   (dir_up),
        .door_open(door_open)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One clock edge of the model: phase timing tracked as elapsed cycles.
    task automatic model_step(input logic rn, input logic [7:0] c);
        int   nm, nf, ne;
        logic nup, ab, be;
        if (!rn) begin
            m_mode = 0; m_floor = 0; m_pend = '0; m_up = 1'b1; m_el = 0;
            return;
        end
        ab = 1'b0; be = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (m_pend[i] && i > m_floor) ab = 1'b1;
            if (m_pend[i] && i < m_floor) be = 1'b1;
        end
        nm = m_mode; nf = m_floor; nup = m_up; ne = m_el + 1;
        case (m_mode)
            0: begin
                ne = 0;
                if (m_pend[m_floor]) nm = 2;
                else if (ab) begin nm = 1; nup = 1'b1; end
                else if (be) begin nm = 1; nup = 1'b0; end
            end
            1: begin
                if (m_el == TRAVEL - 1) begin
                    nf = m_up ? m_floor + 1 : m_floor - 1;
                    ne = 0;
                    if (m_pend[nf]) nm = 2;
                end
            end
            default: begin
                if (c[m_floor]) ne = 0;
                else if (m_el == DOOR - 1) begin
                    ne = 0;
                    if (m_up ? ab : be) nm = 1;
                    else if (m_up ? be : ab) begin nm = 1; nup = ~m_up; end
                    else nm = 0;
                end
            end
        endcase
        m_pend = m_pend | c;
        if (nm == 2) m_pend[nf] = 1'b0;
        m_mode = nm; m_floor = nf; m_up = nup; m_el = ne;
    endtask

    task automatic tick(input logic rn, input logic [7:0] c);
        reset_n  = rn;
        call_req = c;
        @(posedge clk);
        model_step(rn, c);
        #1;
    endtask

    function automatic logic [13:0] obs_vec();
        return {floor, pending, moving, dir_up, door_open};
    endfunction

    function automatic logic [13:0] exp_vec();
        return {3'(m_floor), m_pend, (m_mode == 1), m_up, (m_mode == 2)};
    endfunction

    task automatic test_reset();
        tick(1'b0, 8'hFF);
        tick(1'b0, 8'hFF);
        total++;
        if ({floor, pending, moving, door_open, dir_up} !== {3'd0, 8'h00, 1'b0, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL reset_values: got %h required %h", {floor, pending, moving, door_open, dir_up}, {3'd0, 8'h00, 3'b001});
        end
        total++;
        if (obs_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL reset_model: got %h required %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_single_trip();
        int t1 = -1, t2 = -1, t3 = -1, first_move = -1, doors = 0, door_floor = -1;
        logic up_at_start = 1'b0;
        tick(1'b0, 8'h00);
        tick(1'b1, 8'h08);
        for (int n = 1; n <= 40; n++) begin
            tick(1'b1, 8'h00);
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL trip_model: cycle %0d got %h required %h", n, obs_vec(), exp_vec());
            end
            if (moving && first_move < 0) begin first_move = n; up_at_start = dir_up; end
            if (floor == 3'd1 && t1 < 0) t1 = n;
            if (floor == 3'd2 && t2 < 0) t2 = n;
            if (floor == 3'd3 && t3 < 0) t3 = n;
            if (door_open) begin doors++; door_floor = int'(floor); end
        end
        total++;
        if (first_move != 1 || up_at_start !== 1'b1) begin
            bad++;
            $display("FAIL trip_start: got move@%0d up=%b required move@1 up=1", first_move, up_at_start);
        end
        total++;
        if (t1 != 9 || t2 != 17 || t3 != 25) begin
            bad++;
            $display("FAIL trip_floor_times: got %0d/%0d/%0d required 9/17/25", t1, t2, t3);
        end
        total++;
        if (doors != DOOR || door_floor != 3) begin
            bad++;
            $display("FAIL trip_door: got %0d cycles at floor %0d required %0d at 3", doors, door_floor, DOOR);
        end
        total++;
        if ({pending, moving, door_open} !== 10'h000) begin
            bad++;
            $display("FAIL trip_end_idle: got %h required 000", {pending, moving, door_open});
        end
    endtask

    task automatic test_door_here();
        int first_door = -1, doors = 0;
        logic mv = 1'b0, pend_seen = 1'b0;
        tick(1'b0, 8'h00);
        tick(1'b1, 8'h01);
        for (int n = 1; n <= 12; n++) begin
            tick(1'b1, 8'h00);
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL here_model: cycle %0d got %h required %h", n, obs_vec(), exp_vec());
            end
            if (door_open) begin doors++; if (first_door < 0) first_door = n; end
            if (moving) mv = 1'b1;
            if (pending != 8'h00) pend_seen = 1'b1;
        end
        total++;
        if (first_door != 1 || doors != DOOR || mv !== 1'b0 || pend_seen !== 1'b0) begin
            bad++;
            $display("FAIL here_door: got first=%0d cnt=%0d mv=%b pend=%b required 1/%0d/0/0",
                     first_door, doors, mv, pend_seen, DOOR);
        end
    endtask

    task automatic test_door_reopen();
        logic found = 1'b0, p2 = 1'b0;
        int   doors = 0;
        tick(1'b0, 8'h00);
        tick(1'b1, 8'h04);
        for (int n = 0; n < 60 && !found; n++) begin
            tick(1'b1, 8'h00);
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL reopen_model: got %h required %h", obs_vec(), exp_vec());
            end
            if (door_open) found = 1'b1;
        end
        total++;
        if (!found || floor !== 3'd2) begin
            bad++;
            $display("FAIL reopen_arrive: got found=%b floor=%0d required 1 and 2", found, floor);
        end
        doors = 1;
        for (int j = 1; j <= 12; j++) begin
            tick(1'b1, (j == 4) ? 8'h04 : 8'h00);
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL reopen_model: step %0d got %h required %h", j, obs_vec(), exp_vec());
            end
            if (door_open) doors++;
            if (pending[2]) p2 = 1'b1;
        end
        total++;
        if (doors != 2 * DOOR || p2 !== 1'b0) begin
            bad++;
            $display("FAIL reopen_hold: got door=%0d p2=%b required %0d and 0", doors, p2, 2 * DOOR);
        end
    endtask

    task automatic test_multi_stop();
        logic found = 1'b0, done = 1'b0, prev_door = 1'b0, last_up = 1'b1;
        int   stops[$];
        tick(1'b0, 8'h00);
        tick(1'b1, 8'h80);
        for (int n = 0; n < 60 && !found; n++) begin
            tick(1'b1, 8'h00);
            if (floor == 3'd3 && moving) found = 1'b1;
        end
        total++;
        if (!found || dir_up !== 1'b1) begin
            bad++;
            $display("FAIL multi_reach3: got found=%b up=%b required 1 and 1", found, dir_up);
        end
        tick(1'b1, 8'h21);
        for (int n = 0; n < 300 && !done; n++) begin
            tick(1'b1, 8'h00);
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL multi_model: got %h required %h", obs_vec(), exp_vec());
            end
            if (door_open && !prev_door) begin stops.push_back(int'(floor)); last_up = dir_up; end
            prev_door = door_open;
            if (!moving && !door_open && pending == 8'h00) done = 1'b1;
        end
        total++;
        if (!done || stops.size() != 3 || stops[0] != 5 || stops[1] != 7 || stops[2] != 0 || last_up !== 1'b0) begin
            bad++;
            $display("FAIL multi_stops: got done=%b n=%0d %0d,%0d,%0d up=%b required 1 3 5,7,0 up=0",
                     done, stops.size(), stops[0], stops[1], stops[2], last_up);
        end
    endtask

    task automatic test_reset_mid_move();
        logic found = 1'b0, stray = 1'b0;
        tick(1'b0, 8'h00);
        tick(1'b1, 8'h80);
        for (int n = 0; n < 100 && !found; n++) begin
            tick(1'b1, 8'h00);
            if (floor == 3'd4 && moving) found = 1'b1;
        end
        tick(1'b1, 8'h00);
        tick(1'b1, 8'h00);
        total++;
        if (!found || floor !== 3'd4 || !moving) begin
            bad++;
            $display("FAIL midmove_reach: got found=%b floor=%0d mv=%b required 1/4/1", found, floor, moving);
        end
        tick(1'b0, 8'h20);
        total++;
        if ({floor, pending, moving, door_open, dir_up} !== {3'd0, 8'h00, 3'b001}) begin
            bad++;
            $display("FAIL midmove_reset: got %h required %h", {floor, pending, moving, door_open, dir_up}, {3'd0, 8'h00, 3'b001});
        end
        for (int n = 0; n < 30; n++) begin
            tick(1'b1, 8'h00);
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL midmove_model: got %h required %h", obs_vec(), exp_vec());
            end
            if (moving || door_open || floor != 3'd0) stray = 1'b1;
        end
        total++;
        if (stray !== 1'b0) begin
            bad++;
            $display("FAIL midmove_stale: got activity=%b required 0", stray);
        end
    endtask

    task automatic test_priority();
        logic found = 1'b0, done = 1'b0, prev_door = 1'b0;
        int   stops[$];
        tick(1'b0, 8'h00);
        tick(1'b1, 8'h08);
        for (int n = 0; n < 80 && !found; n++) begin
            tick(1'b1, 8'h00);
            if (floor == 3'd3 && !moving && !door_open && n > 2) found = 1'b1;
        end
        total++;
        if (!found) begin
            bad++;
            $display("FAIL prio_idle3: got found=%b floor=%0d required 1 at 3", found, floor);
        end
        tick(1'b1, 8'h81);
        tick(1'b1, 8'h00);
        total++;
        if (moving !== 1'b1 || dir_up !== 1'b1) begin
            bad++;
            $display("FAIL prio_dir: got mv=%b up=%b required 1/1", moving, dir_up);
        end
        for (int n = 0; n < 300 && !done; n++) begin
            tick(1'b1, 8'h00);
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL prio_model: got %h required %h", obs_vec(), exp_vec());
            end
            if (door_open && !prev_door) stops.push_back(int'(floor));
            prev_door = door_open;
            if (!moving && !door_open && pending == 8'h00) done = 1'b1;
        end
        total++;
        if (!done || stops.size() != 2 || stops[0] != 7 || stops[1] != 0) begin
            bad++;
            $display("FAIL prio_stops: got done=%b n=%0d %0d,%0d required 1 2 7,0",
                     done, stops.size(), stops[0], stops[1]);
        end
    endtask

    task automatic test_random();
        logic       rn;
        logic [7:0] c;
        tick(1'b0, 8'h00);
        for (int n = 0; n < 4000; n++) begin
            rn = ($urandom_range(0, 399) != 0);
            c  = ($urandom_range(0, 3) == 0) ? (8'($urandom) & 8'($urandom)) : 8'h00;
            tick(rn, c);
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL random_model: cycle %0d got %h required %h", n, obs_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_trip();
        test_door_here();
        test_door_reopen();
        test_multi_stop();
        test_reset_mid_move();
        test_priority();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
